// File: rtl/alu_cdb_unit.sv
// ALU responder: one op per run, results queued in order for the CDB; single ops broadcast 2 cycles after run, MUL after MUL_LAT+1.
// busy throttles dispatch while a MUL is pending or the result FIFO is (nearly) full; ALU_BYPASS_EN lets results skip an empty FIFO.

module fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_vld && !pop_vld) begin
      count_d = count_q + 1'b1;
    end else if (!push_vld && pop_vld) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage needs no reset: it is only ever read behind a non-zero count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module alu_cdb_unit #(
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [42:0] instruction_in,
  output logic        busy,
  input  logic        cdb_ready,
  output logic        store_cdb,
  output logic [22:0] solution,
  output logic        op_error
);
  localparam int CW = $clog2(MUL_LAT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ALMOST   = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL_WAIT} state_t;

  typedef struct packed {
    logic [2:0]  tag;
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [15:0] b;
    logic [15:0] c;
  } instr_t;

  state_t        state_q, state_d;
  instr_t        instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_error_q, op_error_d;

  logic          accept;
  logic          can_push;
  logic          res_vld;
  logic [15:0]   result;
  logic [22:0]   res_dat;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [22:0]   fifo_head;
  logic [AW:0]   fifo_count;

  assign busy = (state_q == MUL_WAIT) || (fifo_count == FULL) ||
                ((state_q == EXEC) && (fifo_count == ALMOST));
  assign accept     = run && !busy;
  assign fifo_empty = (fifo_count == '0);
  // A completing MUL may take a slot that is being freed in the same cycle.
  assign can_push   = (fifo_count != FULL) || fifo_pop;

  always_comb begin
    result = 16'h0000;
    case (instr_q.op)
      4'd0: result = instr_q.b + instr_q.c;
      4'd1: result = instr_q.b - instr_q.c;
      4'd2: result = instr_q.b & instr_q.c;
      4'd3: result = instr_q.b | instr_q.c;
      4'd4: result = instr_q.b ^ instr_q.c;
      4'd5: result = {15'h0000, $signed(instr_q.b) < $signed(instr_q.c)};
      4'd6: result = instr_q.b << instr_q.c[3:0];
      4'd7: result = instr_q.b * instr_q.c;
      default: result = 16'h0000;
    endcase
  end

  assign res_dat = {instr_q.dest, instr_q.tag, result};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    op_error_d = 1'b0;
    res_vld    = 1'b0;
    case (state_q)
      EXEC: begin
        res_vld = 1'b1;
        state_d = IDLE;
      end
      MUL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (can_push) begin
          res_vld = 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      if (instruction_in[39]) begin
        op_error_d = 1'b1;
      end else begin
        instr_d = instruction_in;
        if (instruction_in[39:36] == 4'd7) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = EXEC;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      cnt_q      <= '0;
      op_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      op_error_q <= op_error_d;
    end
  end

  assign op_error = op_error_q;

`ifdef ALU_BYPASS_EN
  logic        byp_vld_q, byp_vld_d;
  logic [22:0] byp_dat_q, byp_dat_d;
  logic        do_byp;

  // The bypass slot is always older than anything in the FIFO.
  assign fifo_pop = !byp_vld_q && !fifo_empty && cdb_ready;

  always_comb begin
    do_byp    = res_vld && fifo_empty && cdb_ready;
    fifo_push = res_vld && !do_byp;
    byp_vld_d = do_byp || (byp_vld_q && !cdb_ready);
    byp_dat_d = do_byp ? res_dat : byp_dat_q;
    store_cdb = byp_vld_q || !fifo_empty;
    solution  = byp_vld_q ? byp_dat_q : (fifo_empty ? 23'h0 : fifo_head);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byp_vld_q <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_vld_q <= byp_vld_d;
      byp_dat_q <= byp_dat_d;
    end
  end
`else
  assign fifo_pop = !fifo_empty && cdb_ready;

  always_comb begin
    fifo_push = res_vld;
    store_cdb = !fifo_empty;
    solution  = fifo_empty ? 23'h0 : fifo_head;
  end
`endif

  fifo_sync #(
    .W     (23),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (fifo_push),
    .push_dat (res_dat),
    .pop_vld  (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count)
  );
endmodule

// File: doc/alu_cdb_unit.md
Name: alu_cdb_unit

Overview:
- Execution-side responder for reservation-station dispatch. Accepts one ALU instruction per `run` pulse, executes it, and broadcasts the result on the common data bus (CDB) as a `solution` word with a `store_cdb` strobe.
- Multi-cycle ops are supported, and a result FIFO absorbs CDB back-pressure.
- Sits between the reservation station's dispatch outputs and the CDB arbiter shared with the memory unit.

Parameters:
- MUL_LAT, 3, cycles from MUL acceptance to result-ready (≥2).
- FIFO_DEPTH, 4, result-buffer entries (power of 2, ≥2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  dispatch strobe; instruction_in valid this cycle.
- instruction_in  input  43  [42:40] station tag, [39:36] opcode, [35:32] dest reg, [31:16] operand B, [15:0] operand C.
- busy  output  1  high = unit will not accept `run` this cycle.
- cdb_ready  input  1  arbiter grants CDB this cycle.
- store_cdb  output  1  solution valid strobe.
- solution  output  23  [22:19] dest reg, [18:16] station tag, [15:0] result.
- op_error  output  1  one-cycle pulse: dispatched opcode not an ALU op.

Behaviour:
- Reset (async, any time): all outputs 0; FIFO empty; FSM to IDLE; any in-flight op discarded, no broadcast.
- Opcodes (op[3]=0 only):
  - 0000 ADD, 0001 SUB (B−C), 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: result 1 if signed B < signed C, else 0.
  - 0110 SLL: B << C[3:0].
  - 0111 MUL: low 16 bits of B×C.
  - All arithmetic is 16-bit, wrap-around, no flags.
- op[3]=1 (LW/SW belong to memory): accepted, dropped, `op_error` pulses the next cycle, no result.
- `busy` = (state==MUL_WAIT) OR (FIFO count == FIFO_DEPTH) OR (state==EXEC AND FIFO count == FIFO_DEPTH−1). Combinational.
- `run` while `busy`=1 is ignored (upstream violation). No state change.
- FSM:
  - IDLE: on `run`, latch instruction. Single-cycle op → EXEC. MUL → MUL_WAIT with counter = MUL_LAT−1.
  - EXEC: result computed and pushed into FIFO at end of cycle. If `run` is also high this cycle (busy low), the new instruction is latched back-to-back (→EXEC or MUL_WAIT), else → IDLE. Single-op latency: `run` at cycle N → FIFO entry at N+1 edge → earliest `store_cdb` at N+2.
  - MUL_WAIT: counter decrements each cycle. At 0, push product into FIFO and → IDLE. MUL latency: earliest `store_cdb` at N+MUL_LAT+1.
- CDB output:
  - `store_cdb`/`solution` are registered and present the FIFO head when non-empty.
  - Entry is popped on a cycle where `store_cdb`=1 and `cdb_ready`=1.
  - `store_cdb` stays high, with `solution` held stable, until accepted.
  - `store_cdb`=0 when FIFO empty; `solution` is then don't-care but driven 0.
- Push and pop in the same cycle: count unchanged; ordering strictly FIFO (program-completion order).
- Full FIFO with a completing MUL: the counter freezes at 0 (MUL_WAIT held) until a slot frees. No result is ever lost or overwritten.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- ALU_BYPASS_EN defined: when FIFO is empty and `cdb_ready`=1 at a push, the result skips the FIFO and is broadcast directly next cycle (same timing as normal). The FIFO is not written, so sustained throughput is 1/cycle without consuming entries.
- If `cdb_ready`=0 at that push, normal FIFO push.
- Not defined: every result passes through the FIFO. Latency is identical in both builds; only FIFO occupancy differs (observable via `busy`).

Test Plan:
- Reset pulse mid-MUL (cycle 2 of 3) → no `store_cdb` ever for that op; `busy`=0 after reset; outputs 0.
- ADD tag=3, dest=5, B=0x7FFF, C=0x0001, `cdb_ready`=1 → `store_cdb` at N+2, `solution`={4'h5,3'd3,16'h8000}, held one cycle.
- SLT B=0xFFFF, C=0x0001 → result 0x0001; SUB B=0x0000, C=0x0001 → 0xFFFF; MUL B=0x0100, C=0x0100 → 0x0000, at N+4.
- `cdb_ready`=0, issue 4 ADDs with tags 0..3 → `busy` high after the 4th completes. Raise `cdb_ready` → tags broadcast 0,1,2,3 in consecutive cycles, `solution` stable while stalled.
- MUL (tag 1) then ADD (tag 2) issued when legal → tag 1 broadcast before tag 2; `run` attempted during MUL_WAIT is ignored.
- Opcode 4'b1010 dispatched → `op_error` pulses once, no `store_cdb`, `busy` stays 0.
